// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control types: redirect FSM states, redirect request record and flush polarity.
// Used by branch_redirect_ctrl (optional BRANCH_REDIRECT_STAT_EN counter bank lives in branch_redirect_stat).
package cpu_ctrl_pkg;

    localparam int REQ_PC_W = 32;

    localparam logic FlushEnable  = 1'b1;
    localparam logic FlushDisable = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DS   = 2'd1,
        ST_REDIRECT  = 2'd2,
        ST_KILL_WAIT = 2'd3
    } redirect_state_t;

    typedef struct packed {
        logic                valid;
        logic [REQ_PC_W-1:0] pc;
    } redirect_req_t;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Branch-resolution / front-end redirect bundle between EXE, IF/ID control and the redirect sequencer.
interface branch_redirect_ctrl_if #(
    parameter int PC_W = 32
);
    logic            br_valid;
    logic            br_taken;
    logic            br_likely_nt;
    logic [PC_W-1:0] br_target;
    logic            ds_in_id;
    logic            if_ready;
    logic            exc_flush;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            flush_if;
    logic            flush_id;
    logic            exe_stall;

    modport master (
        output br_valid, br_taken, br_likely_nt, br_target, ds_in_id, if_ready, exc_flush,
        input  redirect_valid, redirect_pc, flush_if, flush_id, exe_stall
    );

    modport slave (
        input  br_valid, br_taken, br_likely_nt, br_target, ds_in_id, if_ready, exc_flush,
        output redirect_valid, redirect_pc, flush_if, flush_id, exe_stall
    );
endinterface

// File: rtl/branch_redirect_stat.sv
// Saturating statistics counters for the redirect sequencer.
// Only present when BRANCH_REDIRECT_STAT_EN is defined.
`ifdef BRANCH_REDIRECT_STAT_EN
module branch_redirect_stat #(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_taken,
    input  logic              inc_ds_wait,
    input  logic              inc_if_stall,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_ds_wait,
    output logic [STAT_W-1:0] stat_if_stall
);

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

    // Counters only clear on rst; an exception flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_taken    <= '0;
            stat_ds_wait  <= '0;
            stat_if_stall <= '0;
        end else begin
            stat_taken    <= sat_inc(stat_taken, inc_taken);
            stat_ds_wait  <= sat_inc(stat_ds_wait, inc_ds_wait);
            stat_if_stall <= sat_inc(stat_if_stall, inc_if_stall);
        end
    end

endmodule
`endif

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer after EXE branch resolution, with delay-slot tracking and likely-NT kill.
// Optional BRANCH_REDIRECT_STAT_EN adds saturating statistics counters and their output ports.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | no branch in flight, accepts br_valid
// ST_WAIT_DS   | taken branch resolved, waiting for delay slot to reach ID
// ST_REDIRECT  | redirect_valid/flush_if held until IF accepts
// ST_KILL_WAIT | likely-not-taken, waiting for delay slot to reach ID to kill it
module branch_redirect_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W = 32
`ifdef BRANCH_REDIRECT_STAT_EN
    , parameter int STAT_W = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_redirect_ctrl_if.slave bus
`ifdef BRANCH_REDIRECT_STAT_EN
    , output logic [STAT_W-1:0]  stat_taken
    , output logic [STAT_W-1:0]  stat_ds_wait
    , output logic [STAT_W-1:0]  stat_if_stall
`endif
);

    redirect_state_t state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            flush_id_q, flush_id_d;
    logic            br_taken_ev;
    logic            br_kill_ev;

    // Taken wins over likely-not-taken if both are (illegally) raised.
    assign br_taken_ev = bus.br_valid & bus.br_taken;
    assign br_kill_ev  = bus.br_valid & ~bus.br_taken & bus.br_likely_nt;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_id_d = FlushDisable;
        case (state_q)
            ST_IDLE: begin
                if (br_taken_ev) begin
                    pc_d    = bus.br_target;
                    state_d = bus.ds_in_id ? ST_REDIRECT : ST_WAIT_DS;
                end else if (br_kill_ev) begin
                    if (bus.ds_in_id) flush_id_d = FlushEnable;
                    else              state_d    = ST_KILL_WAIT;
                end
            end
            ST_WAIT_DS: begin
                if (bus.ds_in_id) state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (valid_q && bus.if_ready) state_d = ST_IDLE;
            end
            ST_KILL_WAIT: begin
                if (bus.ds_in_id) begin
                    flush_id_d = FlushEnable;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.exc_flush) begin
            state_d    = ST_IDLE;
            pc_d       = '0;
            flush_id_d = FlushDisable;
        end
        // Registered redirect is high exactly while the FSM sits in ST_REDIRECT.
        valid_d = (state_d == ST_REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            flush_id_q <= FlushDisable;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            flush_id_q <= flush_id_d;
        end
    end

    assign bus.redirect_valid = valid_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.flush_if       = valid_q ? FlushEnable : FlushDisable;
    assign bus.flush_id       = flush_id_q;
    assign bus.exe_stall      = (state_q != ST_IDLE);

`ifdef BRANCH_REDIRECT_STAT_EN
    branch_redirect_stat #(
        .STAT_W(STAT_W)
    ) u_stat (
        .clk          (clk),
        .rst          (rst),
        .inc_taken    (br_taken_ev),
        .inc_ds_wait  ((state_q == ST_WAIT_DS) || (state_q == ST_KILL_WAIT)),
        .inc_if_stall ((state_q == ST_REDIRECT) && !bus.if_ready),
        .stat_taken   (stat_taken),
        .stat_ds_wait (stat_ds_wait),
        .stat_if_stall(stat_if_stall)
    );
`endif

endmodule
